// File: rtl/ad7276_capture_ctrl.sv
// AD7276 capture sequencer: paces conversion starts at a programmable period and
// frames the packed two-channel results into AXI-Stream bursts.
//
// state     | meaning
// IDLE      | waiting for enable with arm or continuous
// WAIT_TICK | period counter running, start pulse on terminal count
// CONVERT   | conversion in flight, timeout counter running
// OUTPUT    | beat held on AXI-Stream until accepted
module ad7276_capture_ctrl #(
    parameter int ADC_LENGTH = 12,
    parameter int MIN_PERIOD = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_enable,
    input  logic                    i_arm,
    input  logic                    i_continuous,
    input  logic [31:0]             i_period,
    input  logic [15:0]             i_burst_len,
    output logic                    o_conv_start,
    input  logic                    i_conv_done,
    input  logic [2*ADC_LENGTH-1:0] i_conv_data,
    output logic [31:0]             m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    o_busy,
    output logic [15:0]             o_overrun_cnt,
    output logic                    o_timeout
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_CONVERT,
        S_OUTPUT
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     per_cnt_q;
    logic [31:0]     per_reload_q;
    logic [15:0]     idx_q;
    logic [15:0]     last_idx_q;
    logic [TW-1:0]   tmo_cnt_q;
    logic [31:0]     data_q;
    logic            tlast_q;
    logic            timeout_q;
    logic [15:0]     ovr_q;

    logic [31:0]     reload_now;
    logic [15:0]     last_idx_now;
    logic            per_tick;
    logic            leave_idle;
    logic            rearm;
    logic            capture;
    logic            tmo_fire;
    logic            idx_inc;

    assign reload_now   = ((i_period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : i_period) - 32'd1;
    assign last_idx_now = (i_burst_len == 16'd0) ? 16'd0 : i_burst_len - 16'd1;
    assign per_tick     = (per_cnt_q == 32'd0);

    always_comb begin
        state_d      = state_q;
        o_conv_start = 1'b0;
        leave_idle   = 1'b0;
        rearm        = 1'b0;
        capture      = 1'b0;
        tmo_fire     = 1'b0;
        idx_inc      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_enable && (i_continuous || i_arm)) begin
                    leave_idle = 1'b1;
                    state_d    = S_WAIT_TICK;
                end
            end
            S_WAIT_TICK: begin
                if (!i_enable) begin
                    state_d = S_IDLE;
                end else if (per_tick) begin
                    o_conv_start = 1'b1;
                    state_d      = S_CONVERT;
                end
            end
            S_CONVERT: begin
                if (i_conv_done) begin
                    capture = 1'b1;
                    state_d = S_OUTPUT;
                end else if (tmo_cnt_q == '0) begin
                    tmo_fire = 1'b1;
                    state_d  = S_WAIT_TICK;
                end
            end
            S_OUTPUT: begin
                if (m_axis_tready) begin
                    if (tlast_q) begin
                        if (i_continuous && i_enable) begin
                            rearm   = 1'b1;
                            state_d = S_WAIT_TICK;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_inc = 1'b1;
                        state_d = S_WAIT_TICK;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q      <= S_IDLE;
            per_cnt_q    <= 32'd0;
            per_reload_q <= 32'd0;
            idx_q        <= 16'd0;
            last_idx_q   <= 16'd0;
            tmo_cnt_q    <= '0;
            data_q       <= 32'd0;
            tlast_q      <= 1'b0;
            timeout_q    <= 1'b0;
            ovr_q        <= 16'd0;
        end else begin
            state_q <= state_d;

            // Period counter free-runs through every active state so ticks stay on grid.
            if (leave_idle) begin
                per_cnt_q <= reload_now;
            end else if (state_q != S_IDLE) begin
                per_cnt_q <= per_tick ? per_reload_q : per_cnt_q - 32'd1;
            end

            if (leave_idle || rearm) begin
                per_reload_q <= reload_now;
                last_idx_q   <= last_idx_now;
                idx_q        <= 16'd0;
            end else if (idx_inc) begin
                idx_q <= idx_q + 16'd1;
            end

            if (per_tick && (state_q == S_CONVERT || state_q == S_OUTPUT) && ovr_q != 16'hFFFF) begin
                ovr_q <= ovr_q + 16'd1;
            end

            // Loaded so the flag becomes visible exactly TIMEOUT cycles after the start pulse.
            if (o_conv_start) begin
                tmo_cnt_q <= TW'(TIMEOUT - 2);
            end else if (state_q == S_CONVERT && tmo_cnt_q != '0) begin
                tmo_cnt_q <= tmo_cnt_q - 1'b1;
            end

            if (tmo_fire) begin
                timeout_q <= 1'b1;
            end

            if (capture) begin
                data_q  <= {16'(i_conv_data[2*ADC_LENGTH-1:ADC_LENGTH]),
                            16'(i_conv_data[ADC_LENGTH-1:0])};
                tlast_q <= (idx_q == last_idx_q) || !i_enable;
            end
        end
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = (state_q == S_OUTPUT);
    assign m_axis_tlast  = (state_q == S_OUTPUT) && tlast_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_overrun_cnt = ovr_q;
    assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_ad7276_capture_ctrl.sv
// Directed bench for ad7276_capture_ctrl: burst vector table plus hand-written
// overrun, timeout, disable and reset sequences against a simple ADC responder.
module tb_ad7276_capture_ctrl;

    localparam int W_START  = 0;
    localparam int W_TVALID = 1;
    localparam int W_IDLE   = 2;
    localparam int W_TMO    = 3;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    typedef struct {
        logic [31:0] period;
        logic [15:0] burst_len;
        logic [11:0] ch0;
        logic [11:0] ch1;
        int          exp_spacing;
        int          exp_beats;
        logic [31:0] exp_tdata;
    } vec_t;

    logic        i_clk;
    logic        i_rst;
    logic        i_enable;
    logic        i_arm;
    logic        i_continuous;
    logic [31:0] i_period;
    logic [15:0] i_burst_len;
    logic        o_conv_start;
    logic        i_conv_done;
    logic [23:0] i_conv_data;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        o_busy;
    logic [15:0] o_overrun_cnt;
    logic        o_timeout;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          starts[$];
    beat_t       beats[$];
    logic [23:0] adc_data;
    bit          adc_mute;
    int          adc_cnt;
    vec_t        vecs[4];

    ad7276_capture_ctrl #(
        .ADC_LENGTH(12),
        .MIN_PERIOD(16),
        .TIMEOUT   (64)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_enable      (i_enable),
        .i_arm         (i_arm),
        .i_continuous  (i_continuous),
        .i_period      (i_period),
        .i_burst_len   (i_burst_len),
        .o_conv_start  (o_conv_start),
        .i_conv_done   (i_conv_done),
        .i_conv_data   (i_conv_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .o_busy        (o_busy),
        .o_overrun_cnt (o_overrun_cnt),
        .o_timeout     (o_timeout)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Cycle stamps and AXI-Stream capture, sampled between edges.
    initial forever begin
        @(negedge i_clk);
        #1;
        cyc++;
        if (o_conv_start) starts.push_back(cyc);
        if (m_axis_tvalid && m_axis_tready) beats.push_back('{m_axis_tdata, m_axis_tlast});
    end

    // ADC responder: done pulse three cycles after each start unless muted.
    initial begin
        i_conv_done = 1'b0;
        i_conv_data = 24'd0;
        adc_cnt = 0;
        forever begin
            @(negedge i_clk);
            #2;
            i_conv_done = 1'b0;
            if (adc_cnt > 0) begin
                adc_cnt--;
                if (adc_cnt == 0) begin
                    i_conv_done = 1'b1;
                    i_conv_data = adc_data;
                end
            end
            if (o_conv_start && !adc_mute) adc_cnt = 3;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            W_START:  return o_conv_start;
            W_TVALID: return m_axis_tvalid;
            W_IDLE:   return !o_busy;
            W_TMO:    return o_timeout;
            default:  return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int which, input int limit, input string name);
        int n = 0;
        while (!sig(which) && n < limit) begin
            @(negedge i_clk);
            n++;
        end
        if (!sig(which)) begin
            checks++;
            failures++;
            $display("FAIL wait_%s: got no event expected one within %0d cycles", name, limit);
        end
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        i_enable = 1'b0;
        i_arm = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic arm_pulse(output int arm_cyc);
        i_arm = 1'b1;
        arm_cyc = cyc + 1;
        @(negedge i_clk);
        i_arm = 1'b0;
    endtask

    task automatic run_vec(input int v, input vec_t tv);
        int arm_cyc;
        bit ok;
        i_period = tv.period;
        i_burst_len = tv.burst_len;
        adc_data = {tv.ch1, tv.ch0};
        i_continuous = 1'b0;
        m_axis_tready = 1'b1;
        i_enable = 1'b1;
        @(negedge i_clk);
        starts.delete();
        beats.delete();
        arm_pulse(arm_cyc);
        wait_for(W_IDLE, 4000, $sformatf("v%0d_idle", v));
        chk($sformatf("v%0d_n_starts", v), starts.size(), tv.exp_beats);
        if (starts.size() > 0)
            chk($sformatf("v%0d_first_start", v), starts[0] - arm_cyc, tv.exp_spacing);
        ok = 1'b1;
        for (int i = 1; i < starts.size(); i++)
            if (starts[i] - starts[i-1] != tv.exp_spacing) ok = 1'b0;
        chk($sformatf("v%0d_start_spacing_ok", v), ok, 1);
        chk($sformatf("v%0d_n_beats", v), beats.size(), tv.exp_beats);
        for (int i = 0; i < beats.size(); i++) begin
            chk($sformatf("v%0d_tdata%0d", v, i), beats[i].d, tv.exp_tdata);
            chk($sformatf("v%0d_tlast%0d", v, i), beats[i].l, (i == beats.size() - 1) ? 1 : 0);
        end
    endtask

    initial begin
        int s0;
        int arm_cyc;
        logic [31:0] d0;
        bit stable;

        vecs[0] = '{32'd100, 16'd4, 12'h123, 12'hABC, 100, 4, 32'h0ABC_0123};
        vecs[1] = '{32'd5,   16'd3, 12'hFFF, 12'h000, 16,  3, 32'h0000_0FFF};
        vecs[2] = '{32'd16,  16'd0, 12'h001, 12'h800, 16,  1, 32'h0800_0001};
        vecs[3] = '{32'd17,  16'd2, 12'h555, 12'hAAA, 17,  2, 32'h0AAA_0555};

        i_rst = 1'b0;
        i_enable = 1'b0;
        i_arm = 1'b0;
        i_continuous = 1'b0;
        i_period = 32'd100;
        i_burst_len = 16'd1;
        m_axis_tready = 1'b0;
        adc_data = 24'd0;
        adc_mute = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_conv_start", o_conv_start, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_overrun", o_overrun_cnt, 0);
        chk("rst_timeout", o_timeout, 0);
        i_rst = 1'b1;
        @(negedge i_clk);

        for (int v = 0; v < 4; v++) run_vec(v, vecs[v]);
        chk("vec_overrun", o_overrun_cnt, 0);
        chk("vec_timeout", o_timeout, 0);

        // Continuous mode with a 120-cycle stall: two ticks land in OUTPUT.
        do_reset();
        adc_data = {12'hABC, 12'h123};
        i_period = 32'd50;
        i_burst_len = 16'd2;
        i_continuous = 1'b1;
        m_axis_tready = 1'b0;
        starts.delete();
        beats.delete();
        i_enable = 1'b1;
        wait_for(W_START, 200, "ovr_start");
        s0 = cyc + 1;
        wait_for(W_TVALID, 50, "ovr_tvalid");
        chk("tvalid_latency", cyc + 1 - s0, 4);
        d0 = m_axis_tdata;
        chk("ovr_tdata", d0, 32'h0ABC_0123);
        stable = 1'b1;
        repeat (120) begin
            if (!(m_axis_tvalid && m_axis_tdata == d0 && !m_axis_tlast)) stable = 1'b0;
            @(negedge i_clk);
        end
        chk("stall_stable", stable, 1);
        chk("stall_starts", starts.size(), 1);
        m_axis_tready = 1'b1;
        @(negedge i_clk);
        chk("ovr_beats", beats.size(), 1);
        chk("ovr_cnt", o_overrun_cnt, 2);
        wait_for(W_START, 200, "ovr_next_start");
        chk("ovr_next_start", cyc + 1 - s0, 150);
        @(negedge i_clk);
        i_enable = 1'b0;
        wait_for(W_IDLE, 100, "ovr_idle");
        chk("ovr_beats_end", beats.size(), 2);
        if (beats.size() == 2) chk("ovr_tlast_end", beats[1].l, 1);

        // Conversion timeout: muted ADC, flag at start+64, no beat, index kept.
        do_reset();
        adc_data = {12'h321, 12'h654};
        i_period = 32'd100;
        i_burst_len = 16'd2;
        i_continuous = 1'b0;
        m_axis_tready = 1'b1;
        adc_mute = 1'b1;
        i_enable = 1'b1;
        starts.delete();
        beats.delete();
        arm_pulse(arm_cyc);
        wait_for(W_START, 200, "tmo_start");
        repeat (63) @(negedge i_clk);
        chk("tmo_before", o_timeout, 0);
        @(negedge i_clk);
        chk("tmo_set", o_timeout, 1);
        chk("tmo_no_beat", beats.size(), 0);
        adc_mute = 1'b0;
        wait_for(W_IDLE, 400, "tmo_idle");
        chk("tmo_sticky", o_timeout, 1);
        chk("tmo_starts", starts.size(), 3);
        if (starts.size() >= 2) chk("tmo_next_start", starts[1] - starts[0], 100);
        chk("tmo_beats", beats.size(), 2);
        if (beats.size() == 2) begin
            chk("tmo_tlast0", beats[0].l, 0);
            chk("tmo_tlast1", beats[1].l, 1);
            chk("tmo_tdata", beats[1].d, 32'h0321_0654);
        end

        // Disable during CONVERT of sample 2 of 8 closes the packet.
        i_enable = 1'b1;
        i_period = 32'd20;
        i_burst_len = 16'd8;
        @(negedge i_clk);
        starts.delete();
        beats.delete();
        arm_pulse(arm_cyc);
        wait_for(W_START, 100, "dis_start1");
        @(negedge i_clk);
        wait_for(W_START, 100, "dis_start2");
        @(negedge i_clk);
        i_enable = 1'b0;
        wait_for(W_IDLE, 100, "dis_idle");
        chk("dis_starts", starts.size(), 2);
        chk("dis_beats", beats.size(), 2);
        if (beats.size() == 2) begin
            chk("dis_tlast0", beats[0].l, 0);
            chk("dis_tlast1", beats[1].l, 1);
        end

        // Reset while a beat is stalled with overrun and timeout both set.
        do_reset();
        i_period = 32'd16;
        i_burst_len = 16'd1;
        i_continuous = 1'b1;
        m_axis_tready = 1'b0;
        adc_mute = 1'b1;
        i_enable = 1'b1;
        wait_for(W_START, 100, "rst_seq_start");
        wait_for(W_TMO, 100, "rst_seq_tmo");
        adc_mute = 1'b0;
        wait_for(W_TVALID, 100, "rst_seq_tvalid");
        chk("pre_rst_overrun", o_overrun_cnt, 3);
        chk("pre_rst_timeout", o_timeout, 1);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("mid_rst_tvalid", m_axis_tvalid, 0);
        chk("mid_rst_tlast", m_axis_tlast, 0);
        chk("mid_rst_overrun", o_overrun_cnt, 0);
        chk("mid_rst_timeout", o_timeout, 0);
        chk("mid_rst_busy", o_busy, 0);
        i_enable = 1'b0;
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("post_rst_busy", o_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
